pdm_cic_decimator: RTL
======================

// Module: pdm_cic_decimator
// PURPOSE
//  Consumes the divided microphone clock (~1 MHz square wave, registered in the 100 MHz domain) and the mic's PDM bit.
//  Samples one PDM bit per mic-clock rising edge, decimates with a 2nd-order CIC filter and emits signed PCM samples.
//  Output: pcm_sample plus a one-cycle pcm_valid strobe for the recorder's sample buffer.
// PARAMETERS
//  DECIM   64   PDM bits per PCM sample; power of two, 4..256
//  LOG2_D  6    log2(DECIM); must match DECIM
//  OUT_W   16   pcm_sample width; must be >= 2*LOG2_D+1
// PORTS
//  clock       in   1      100 MHz system clock; sole clock
//  reset_n     in   1      synchronous active-low reset
//  enable      in   1      1 = run; 0 = clear filter state and hold outputs
//  scaled_clk  in   1      divided mic clock, registered in clock domain
//  pdm_data    in   1      mic PDM bit, asynchronous to clock
//  pcm_sample  out  OUT_W  signed two's-complement PCM sample
//  pcm_valid   out  1      one-cycle strobe, pcm_sample new this cycle
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clock): pcm_sample=0, pcm_valid=0, integrators/combs/counters=0, warm-up count=0.
//  pdm_data: 2-FF synchroniser. scaled_clk: 1 delay register; rise = scaled_clk & ~scaled_clk_d.
//  Bit strobe: one cycle after rise, take synchronised bit x (0/1). Sampled only if enable=1 on that cycle.
//  Rise spacing >= 4 clocks is required; actual spacing here is ~102.
//  Integrators: ACC_W = 2*LOG2_D+1 bits, unsigned, modulo wrap by design.
//  On each bit strobe: I1 <= I1 + x; I2 <= I2 + I1 (old I1).
//  bit_cnt: LOG2_D bits, +1 per strobe, wraps DECIM-1 -> 0.
//  Decimation tick = strobe with bit_cnt==DECIM-1. Comb, computed with the I2 value after that strobe's update:
//    c1 = I2 - I2_d; c2 = c1 - c1_d; raw = c2 (modulo ACC_W).
//    Then I2_d <= I2, c1_d <= c1.
//  raw range 0..DECIM^2. pcm = (raw - DECIM^2/2) as ACC_W signed, then shifted left by OUT_W-ACC_W.
//  Latency: pcm_sample and pcm_valid update on the clock edge after the tick strobe, i.e. 2 clocks after the rise.
//  Warm-up: first 2 ticks after reset or enable rise only prime comb history.
//    pcm_valid stays 0 and pcm_sample holds during warm-up. Third tick onward: valid output every tick.
//  enable=0: clears I1, I2, I2_d, c1_d, bit_cnt and warm-up count; pcm_valid=0; pcm_sample holds last value.
//    Clearing wins over a coincident strobe or tick.
//  Reset or enable drop mid-window: the partial window is discarded; the next window starts at bit_cnt=0.
//  pcm_valid never asserts on two consecutive cycles.
//  DC full scale (DECIM=64, OUT_W=16): all ones -> +16384; all zeros -> -16384; 50% density -> 0.
// STRUCTURE
//  Shared include audio_defs.vh holds:
//    DECIM/LOG2_D defaults, ACC_W formula, OUT_W default, full-scale constant DECIM^2/2.
//    The recorder buffer also uses these.
//  Sub-module pdm_bit_sampler: synchroniser, edge detector, enable gating.
//    Outputs bit_strobe and bit_val. Top level holds CIC, counters and output registers.
// TESTING (DECIM=64, OUT_W=16, scaled_clk toggling every 51 clocks)
//  1. pdm_data=1 constant, enable=1 from reset:
//     -> no pcm_valid for first 128 bits; then pcm_sample=16384 every 64 bits, valid exactly 1 cycle each.
//  2. pdm_data=0 constant -> steady pcm_sample=-16384 (0xC000) after warm-up.
//  3. pdm_data alternating 1,0 per mic edge -> pcm_sample=0 each valid after warm-up.
//     25% density (1 in 4) -> -8192.
//  4. enable dropped at bit 30 of a window, raised 10 mic periods later with all ones:
//     -> pcm_valid low during the drop; 2 silent ticks; then 16384. pcm_sample holds prior value throughout.
//  5. reset_n pulsed low for 1 clock, coincident with a tick strobe:
//     -> no pcm_valid that cycle; all state zero next cycle; warm-up restarts.
//  6. Long run, >2^13 bits, random density p=0.75:
//     -> compare against a software CIC model; mean pcm ~ +8192. Integrator wrap causes no glitch.

Source files
------------

// File: rtl/pdm_cic_decimator_pkg.sv
// rtl/pdm_cic_decimator_pkg.sv - shared audio constants and helpers for the PDM CIC decimator
package pdm_cic_decimator_pkg;

  localparam int DECIM_DEF  = 64;
  localparam int LOG2_D_DEF = 6;
  localparam int OUT_W_DEF  = 16;

  typedef enum logic [1:0] {
    WARM_0,
    WARM_1,
    WARM_DONE
  } warm_e;

  function automatic int acc_w(input int log2_d);
    return 2 * log2_d + 1;
  endfunction

  function automatic int full_scale(input int decim);
    return (decim * decim) / 2;
  endfunction

endpackage

// File: rtl/pdm_cic_decimator_if.sv
// rtl/pdm_cic_decimator_if.sv - mic input and PCM output signals of the decimator
interface pdm_cic_decimator_if
  import pdm_cic_decimator_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) ();

  logic             scaled_clk;
  logic             pdm_data;
  logic [OUT_W-1:0] pcm_sample;
  logic             pcm_valid;

  modport master (
    input  scaled_clk,
    input  pdm_data,
    output pcm_sample,
    output pcm_valid
  );

  modport slave (
    output scaled_clk,
    output pdm_data,
    input  pcm_sample,
    input  pcm_valid
  );

endinterface

// File: rtl/pdm_bit_sampler.sv
// rtl/pdm_bit_sampler.sv - synchronises the PDM bit and strobes it one clock after each mic-clock rise
module pdm_bit_sampler (
  input  logic clock,
  input  logic reset_n,
  input  logic i_enable,
  input  logic i_scaled_clk,
  input  logic i_pdm_data,
  output logic o_bit_strobe,
  output logic o_bit_val
);

  logic r_pdm_meta;
  logic r_pdm_sync;
  logic r_sclk_d;
  logic r_rise_d;
  logic w_rise;

  assign w_rise = i_scaled_clk & ~r_sclk_d;

  // The edge-detect delay keeps tracking through reset so a high mic clock
  // at reset release is not mistaken for a fresh rise.
  always_ff @(posedge clock) begin
    r_sclk_d <= i_scaled_clk;
    if (!reset_n) begin
      r_pdm_meta <= 1'b0;
      r_pdm_sync <= 1'b0;
      r_rise_d   <= 1'b0;
    end else begin
      r_pdm_meta <= i_pdm_data;
      r_pdm_sync <= r_pdm_meta;
      r_rise_d   <= w_rise;
    end
  end

  assign o_bit_strobe = r_rise_d & i_enable;
  assign o_bit_val    = r_pdm_sync;

endmodule

// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - 2nd-order CIC decimator turning a PDM bitstream into signed PCM samples
module pdm_cic_decimator
  import pdm_cic_decimator_pkg::*;
#(
  parameter int DECIM  = DECIM_DEF,
  parameter int LOG2_D = LOG2_D_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  pdm_cic_decimator_if.master   bus
);

  localparam int                ACC_W = acc_w(LOG2_D);
  localparam int                SHIFT = OUT_W - ACC_W;
  localparam logic [ACC_W-1:0]  FULL  = ACC_W'(full_scale(DECIM));
  localparam logic [LOG2_D-1:0] LAST  = LOG2_D'(DECIM - 1);

  logic w_bit_strobe;
  logic w_bit_val;

  logic [ACC_W-1:0]  r_i1;
  logic [ACC_W-1:0]  r_i2;
  logic [ACC_W-1:0]  r_i2_d;
  logic [ACC_W-1:0]  r_c1_d;
  logic [LOG2_D-1:0] r_bit_cnt;
  warm_e             r_warm;
  logic [OUT_W-1:0]  r_pcm;
  logic              r_valid;

  logic [ACC_W-1:0]        w_i2_next;
  logic [ACC_W-1:0]        w_c1;
  logic [ACC_W-1:0]        w_c2;
  logic signed [ACC_W-1:0] w_centered;
  logic signed [OUT_W-1:0] w_pcm;

  pdm_bit_sampler u_sampler (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_enable     (enable),
    .i_scaled_clk (bus.scaled_clk),
    .i_pdm_data   (bus.pdm_data),
    .o_bit_strobe (w_bit_strobe),
    .o_bit_val    (w_bit_val)
  );

  // Integrators and combs wrap modulo ACC_W; the comb difference is exact
  // because the true output never exceeds DECIM^2.
  assign w_i2_next  = r_i2 + r_i1;
  assign w_c1       = w_i2_next - r_i2_d;
  assign w_c2       = w_c1 - r_c1_d;
  assign w_centered = $signed(w_c2 - FULL);
  assign w_pcm      = OUT_W'(w_centered) <<< SHIFT;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_i1      <= '0;
      r_i2      <= '0;
      r_i2_d    <= '0;
      r_c1_d    <= '0;
      r_bit_cnt <= '0;
      r_warm    <= WARM_0;
      r_pcm     <= '0;
      r_valid   <= 1'b0;
    end else if (!enable) begin
      r_i1      <= '0;
      r_i2      <= '0;
      r_i2_d    <= '0;
      r_c1_d    <= '0;
      r_bit_cnt <= '0;
      r_warm    <= WARM_0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_bit_strobe) begin
        r_i1      <= r_i1 + ACC_W'(w_bit_val);
        r_i2      <= w_i2_next;
        r_bit_cnt <= r_bit_cnt + LOG2_D'(1);
        if (r_bit_cnt == LAST) begin
          r_i2_d <= w_i2_next;
          r_c1_d <= w_c1;
          // The first two ticks only fill the comb history.
          case (r_warm)
            WARM_0:  r_warm <= WARM_1;
            WARM_1:  r_warm <= WARM_DONE;
            default: begin
              r_pcm   <= w_pcm;
              r_valid <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign bus.pcm_sample = r_pcm;
  assign bus.pcm_valid  = r_valid;

endmodule
